// File: rtl/rep_add_multiplier.sv
// Sequential multiplier by repeated addition with operand swap, start/busy/done
// handshake and optional two's-complement mode.
module rep_add_multiplier #(
  parameter int unsigned WIDTH  = 8,
  parameter bit          SIGNED = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] r1_q;
  logic [WIDTH-1:0] r2_q;
  logic [PW-1:0]    r3_q;
  logic             neg_q;
  logic             busy_q;
  logic             done_q;
  logic [PW-1:0]    product_q;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  // Operand magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1), which fits unsigned.
  always_comb begin
    a_neg = SIGNED && a[WIDTH-1];
    b_neg = SIGNED && b[WIDTH-1];
    a_mag = a_neg ? WIDTH'(-a) : a;
    b_mag = b_neg ? WIDTH'(-b) : b;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      r1_q      <= '0;
      r2_q      <= '0;
      r3_q      <= '0;
      neg_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            r1_q    <= a_mag;
            r2_q    <= b_mag;
            neg_q   <= a_neg ^ b_neg;
            r3_q    <= '0;
            busy_q  <= 1'b1;
            state_q <= CMP;
          end
        end
        CMP: begin
          // Smaller magnitude becomes the iteration counter.
          if (r2_q < r1_q) begin
            r1_q <= r2_q;
            r2_q <= r1_q;
          end
          state_q <= MUL;
        end
        MUL: begin
          if (r1_q != '0) begin
            r3_q <= r3_q + PW'(r2_q);
            r1_q <= r1_q - WIDTH'(1);
          end else begin
            product_q <= neg_q ? PW'(-r3_q) : r3_q;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_rep_add_multiplier.sv
// Self-checking bench for rep_add_multiplier: unsigned and signed instances
// checked against an integer-arithmetic reference model.
module tb_rep_add_multiplier;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic           start_u, start_s;
  logic [W-1:0]   a_u, b_u, a_s, b_s;
  logic           busy_u, busy_s, done_u, done_s;
  logic [2*W-1:0] product_u, product_s;

  int checks = 0;
  int errors = 0;

  rep_add_multiplier #(.WIDTH(W), .SIGNED(1'b0)) u_dut_u (
    .clk(clk), .rst(rst), .start(start_u), .a(a_u), .b(b_u),
    .busy(busy_u), .done(done_u), .product(product_u)
  );

  rep_add_multiplier #(.WIDTH(W), .SIGNED(1'b1)) u_dut_s (
    .clk(clk), .rst(rst), .start(start_s), .a(a_s), .b(b_s),
    .busy(busy_s), .done(done_s), .product(product_s)
  );

  // Reference model: plain integer arithmetic.
  function automatic int sval(input bit sgn, input logic [W-1:0] v);
    return sgn ? int'($signed(v)) : int'(v);
  endfunction

  function automatic int mag(input bit sgn, input logic [W-1:0] v);
    int s;
    s = sval(sgn, v);
    return (s < 0) ? -s : s;
  endfunction

  function automatic logic [2*W-1:0] ref_prod(input bit sgn, input logic [W-1:0] av, input logic [W-1:0] bv);
    int p;
    p = sval(sgn, av) * sval(sgn, bv);
    return 16'(p);
  endfunction

  function automatic int ref_lat(input bit sgn, input logic [W-1:0] av, input logic [W-1:0] bv);
    int ma, mb;
    ma = mag(sgn, av);
    mb = mag(sgn, bv);
    return ((ma < mb) ? ma : mb) + 2;
  endfunction

  function automatic logic cur_busy(input bit sgn);
    return sgn ? busy_s : busy_u;
  endfunction

  function automatic logic cur_done(input bit sgn);
    return sgn ? done_s : done_u;
  endfunction

  function automatic logic [2*W-1:0] cur_prod(input bit sgn);
    return sgn ? product_s : product_u;
  endfunction

  task automatic drive(input bit sgn, input logic st, input logic [W-1:0] av, input logic [W-1:0] bv);
    if (sgn) begin
      start_s = st; a_s = av; b_s = bv;
    end else begin
      start_u = st; a_u = av; b_u = bv;
    end
  endtask

  // Called right after the accepting edge. mode 0: start low, 1: random start,
  // 2: start held high; operands are scrambled in all modes.
  task automatic wait_done(input bit sgn, input int mode, output int lat, output bit seen, output bit busy_ok);
    int k;
    k = 0; seen = 1'b0; busy_ok = 1'b1; lat = -1;
    while (!seen && k < 400) begin
      @(negedge clk);
      if (!cur_busy(sgn)) busy_ok = 1'b0;
      if (cur_done(sgn)) begin
        seen = 1'b1;
        lat  = k;
      end else begin
        drive(sgn, (mode == 2) ? 1'b1 : (mode == 1) ? 1'($urandom) : 1'b0,
              8'($urandom), 8'($urandom));
        @(posedge clk);
        k++;
      end
    end
  endtask

  task automatic run_op(input bit sgn, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input int mode, input string name);
    int lat, exp_lat;
    bit seen, busy_ok;
    logic [2*W-1:0] exp_p;
    exp_p   = ref_prod(sgn, av, bv);
    exp_lat = ref_lat(sgn, av, bv);
    @(negedge clk);
    drive(sgn, 1'b1, av, bv);
    @(posedge clk);
    wait_done(sgn, mode, lat, seen, busy_ok);
    drive(sgn, 1'b0, av, bv);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s timeout: no done (a=%0h b=%0h)", name, av, bv);
    end
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d (a=%0h b=%0h)", name, lat, exp_lat, av, bv);
    end
    checks++;
    if (cur_prod(sgn) !== exp_p) begin
      errors++;
      $display("FAIL %s product: got %0h expected %0h (a=%0h b=%0h)", name, cur_prod(sgn), exp_p, av, bv);
    end
    checks++;
    if (!busy_ok) begin
      errors++;
      $display("FAIL %s busy: got 0 expected 1 during operation", name);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (cur_done(sgn) !== 1'b0 || cur_busy(sgn) !== 1'b0) begin
      errors++;
      $display("FAIL %s after done: done=%b busy=%b expected 0 0", name, cur_done(sgn), cur_busy(sgn));
    end
    checks++;
    if (cur_prod(sgn) !== exp_p) begin
      errors++;
      $display("FAIL %s product hold: got %0h expected %0h", name, cur_prod(sgn), exp_p);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    drive(1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, '0, '0);
    #1;
    checks++;
    if ({busy_u, done_u, product_u, busy_s, done_s, product_s} !== '0) begin
      errors++;
      $display("FAIL reset: u busy=%b done=%b prod=%0h s busy=%b done=%b prod=%0h expected all 0",
               busy_u, done_u, product_u, busy_s, done_s, product_s);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_directed;
    run_op(1'b0, 8'd13,  8'd200, 0, "u_13x200");
    run_op(1'b0, 8'd200, 8'd13,  0, "u_200x13");
    run_op(1'b0, 8'd0,   8'd255, 0, "u_0x255");
    run_op(1'b0, 8'd255, 8'd255, 0, "u_255x255");
    run_op(1'b1, 8'hF9,  8'h06,  0, "s_m7x6");
    run_op(1'b1, 8'h80,  8'h80,  0, "s_m128xm128");
    run_op(1'b1, 8'hFB,  8'h00,  0, "s_m5x0");
    run_op(1'b1, 8'h7F,  8'h80,  0, "s_127xm128");
  endtask

  task automatic test_random;
    for (int i = 0; i < 12; i++) begin
      run_op(1'b0, 8'($urandom), 8'($urandom), 1, "u_rand");
      run_op(1'b1, 8'($urandom), 8'($urandom), (i % 2), "s_rand");
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    bit seen, busy_ok;
    @(negedge clk);
    drive(1'b0, 1'b1, 8'd5, 8'd7);
    @(posedge clk);
    wait_done(1'b0, 2, lat, seen, busy_ok);
    drive(1'b0, 1'b1, 8'd9, 8'd2);
    checks++;
    if (!seen || lat !== 7 || product_u !== 16'd35) begin
      errors++;
      $display("FAIL b2b first: seen=%b lat=%0d prod=%0d expected 1 7 35", seen, lat, product_u);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy_u !== 1'b0) begin
      errors++;
      $display("FAIL b2b idle gap: busy=%b expected 0", busy_u);
    end
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 8'd0, 8'd0);
    checks++;
    if (busy_u !== 1'b1) begin
      errors++;
      $display("FAIL b2b reaccept: busy=%b expected 1", busy_u);
    end
    // One edge already elapsed since acceptance; wait_done counts from there.
    @(posedge clk);
    wait_done(1'b0, 0, lat, seen, busy_ok);
    drive(1'b0, 1'b0, 8'd0, 8'd0);
    checks++;
    if (!seen || lat + 1 !== 4 || product_u !== 16'd18) begin
      errors++;
      $display("FAIL b2b second: seen=%b lat=%0d prod=%0d expected 1 4 18", seen, lat + 1, product_u);
    end
    @(posedge clk);
  endtask

  task automatic test_reset_mid;
    bit saw_done;
    run_op(1'b0, 8'd13, 8'd200, 0, "u_pre_reset");
    @(negedge clk);
    drive(1'b0, 1'b1, 8'd100, 8'd100);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 8'd100, 8'd100);
    repeat (20) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (busy_u !== 1'b0 || done_u !== 1'b0 || product_u !== '0) begin
      errors++;
      $display("FAIL reset mid-op: busy=%b done=%b prod=%0h expected 0 0 0", busy_u, done_u, product_u);
    end
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done_u) saw_done = 1'b1;
    end
    rst = 1'b1;
    repeat (110) begin
      @(negedge clk);
      if (done_u || busy_u) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL reset discard: got activity after reset expected none");
    end
    run_op(1'b0, 8'd3, 8'd4, 0, "u_post_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
